conv_window_sequencer: RTL and testbench

Controller that sequences a bit-serial AND-accumulate (binary dot-product) datapath over a sliding window of a serial input bitstream. It holds a loadable WIDTH-bit kernel and a WIDTH-bit sample window. For every accepted sample, once the window is full, it runs WIDTH multiply-accumulate cycles and presents popcount(window & kernel) on a valid/ready output. It sits between the chip-level io pins and downstream result logic.

---
 rtl/conv_window_sequencer.sv | 133 +++++++++++++
 tb/tb_conv_window_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sequencer.sv
// Sliding-window binary dot-product sequencer: shifts serial samples into a
// WIDTH-bit window and, once full, runs WIDTH AND-accumulate cycles per sample.
module conv_window_sequencer #(
  parameter int WIDTH = 6,
  parameter int SUM_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             kernel_load,
  input  logic [WIDTH-1:0] kernel_in,
  input  logic             sample_valid,
  input  logic             sample_bit,
  output logic             sample_ready,
  output logic             result_valid,
  output logic [SUM_W-1:0] result,
  input  logic             result_ready,
  output logic             busy
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam int IDX_W  = $clog2(WIDTH);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  kernel_reg, kernel_next;
  logic [WIDTH-1:0]  window_reg, window_next;
  logic [FILL_W-1:0] fill_reg, fill_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [SUM_W-1:0]  acc_reg, acc_next;
  logic [SUM_W-1:0]  result_reg, result_next;
  logic              result_valid_reg, result_valid_next;

  logic [WIDTH-1:0]  product;
  logic [SUM_W-1:0]  mac_sum;
  logic              accept;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_prod
      assign product[gi] = window_reg[gi] & kernel_reg[gi];
    end
  endgenerate

  // Reset is folded in so no sample looks acceptable while reset is held.
  assign sample_ready = (state_reg == IDLE) && !clear && !kernel_load && !reset;
  assign accept       = sample_valid && sample_ready;
  assign mac_sum      = acc_reg + SUM_W'(product[idx_reg]);

  assign busy         = (state_reg != IDLE);
  assign result_valid = result_valid_reg;
  assign result       = result_reg;

  always_comb begin
    state_next        = state_reg;
    kernel_next       = kernel_reg;
    window_next       = window_reg;
    fill_next         = fill_reg;
    idx_next          = idx_reg;
    acc_next          = acc_reg;
    result_next       = result_reg;
    result_valid_next = result_valid_reg;

    if (clear) begin
      // Abort and flush; the kernel and last presented result survive.
      state_next        = IDLE;
      window_next       = '0;
      fill_next         = '0;
      idx_next          = '0;
      acc_next          = '0;
      result_valid_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (kernel_load) begin
            kernel_next = kernel_in;
          end else if (accept) begin
            window_next = {window_reg[WIDTH-2:0], sample_bit};
            fill_next   = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + FILL_W'(1);
            if (fill_reg >= FILL_LAST) begin
              state_next = MAC;
              idx_next   = '0;
              acc_next   = '0;
            end
          end
        end
        MAC: begin
          acc_next = mac_sum;
          idx_next = idx_reg + IDX_W'(1);
          if (idx_reg == IDX_LAST) begin
            idx_next          = '0;
            result_next       = mac_sum;
            result_valid_next = 1'b1;
            state_next        = DONE;
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid_next = 1'b0;
            state_next        = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      kernel_reg       <= '0;
      window_reg       <= '0;
      fill_reg         <= '0;
      idx_reg          <= '0;
      acc_reg          <= '0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      kernel_reg       <= kernel_next;
      window_reg       <= window_next;
      fill_reg         <= fill_next;
      idx_reg          <= idx_next;
      acc_reg          <= acc_next;
      result_reg       <= result_next;
      result_valid_reg <= result_valid_next;
    end
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: cycle table, directed corner cases and
// randomized traffic against a sample-history dot-product model.
module tb_conv_window_sequencer;

  localparam int WIDTH = 6;
  localparam int SUM_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             clear = 1'b0;
  logic             kernel_load = 1'b0;
  logic [WIDTH-1:0] kernel_in = '0;
  logic             sample_valid = 1'b0;
  logic             sample_bit = 1'b0;
  logic             result_ready = 1'b0;
  logic             sample_ready;
  logic             result_valid;
  logic [SUM_W-1:0] result;
  logic             busy;

  conv_window_sequencer #(.WIDTH(WIDTH), .SUM_W(SUM_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .kernel_load (kernel_load),
    .kernel_in   (kernel_in),
    .sample_valid(sample_valid),
    .sample_bit  (sample_bit),
    .sample_ready(sample_ready),
    .result_valid(result_valid),
    .result      (result),
    .result_ready(result_ready),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: accepted samples oldest first, plus the kernel in force.
  bit               hist[$];
  logic [WIDTH-1:0] kernel_m = '0;

  function automatic int model_res();
    int s = 0;
    for (int i = 0; i < WIDTH; i++)
      if (hist[hist.size()-1-i] && kernel_m[i]) s++;
    return s;
  endfunction

  typedef struct {
    logic             clr, kl;
    logic [WIDTH-1:0] kin;
    logic             sv, sb, rr;
    logic             e_sr, e_rv, e_busy;
    logic [SUM_W-1:0] e_res;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic clr, kl, input logic [WIDTH-1:0] kin,
                         input logic sv, sb, rr, e_sr, e_rv, e_busy,
                         input logic [SUM_W-1:0] e_res);
    vec_t v;
    v.clr = clr; v.kl = kl; v.kin = kin; v.sv = sv; v.sb = sb; v.rr = rr;
    v.e_sr = e_sr; v.e_rv = e_rv; v.e_busy = e_busy; v.e_res = e_res;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 1'b0; kernel_load = 1'b0; sample_valid = 1'b0; result_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    chk("rst_sready", sample_ready, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    #3 reset = 1'b0;
    step();
    chk("rst_idle_sready", sample_ready, 1);
    hist.delete();
    kernel_m = '0;
  endtask

  task automatic load_kernel(input logic [WIDTH-1:0] k);
    kernel_load = 1'b1; kernel_in = k;
    #1 chk("kl_sready", sample_ready, 0);
    step();
    kernel_load = 1'b0;
    kernel_m = k;
  endtask

  task automatic send(input bit b);
    sample_valid = 1'b1; sample_bit = b;
    #1 chk("send_sready", sample_ready, 1);
    step();
    sample_valid = 1'b0;
    hist.push_back(b);
    if (hist.size() > WIDTH) void'(hist.pop_front());
    if (hist.size() == WIDTH) begin
      chk("send_busy_full", busy, 1);
    end else begin
      chk("send_busy_fill", busy, 0);
      chk("send_rv_fill", result_valid, 0);
    end
  endtask

  // Waits for the result (start = edges already elapsed since the accept),
  // holds it for bp cycles, then hands it off.
  task automatic get_result(input string tag, input int start, input int bp);
    int cyc = start;
    int exp = model_res();
    while (!result_valid && cyc < WIDTH + 4) begin
      step();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, WIDTH);
    chk({tag, "_rv"}, result_valid, 1);
    chk({tag, "_result"}, result, exp);
    for (int i = 0; i < bp; i++) begin
      sample_valid = 1'b1; sample_bit = 1'($urandom);
      step();
      chk({tag, "_bp_rv"}, result_valid, 1);
      chk({tag, "_bp_result"}, result, exp);
      chk({tag, "_bp_busy"}, busy, 1);
      chk({tag, "_bp_sready"}, sample_ready, 0);
    end
    sample_valid = 1'b0; result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk({tag, "_hs_rv"}, result_valid, 0);
    chk({tag, "_hs_busy"}, busy, 0);
    chk({tag, "_hs_sready"}, sample_ready, 1);
    $display("result %s: got=%0d exp=%0d kernel=%b bp=%0d", tag, result, exp, kernel_m, bp);
  endtask

  // Accept a window-completing sample, then clear on MAC edge number 'at'.
  task automatic mac_clear(input bit b, input int at);
    bit rose = 1'b0;
    send(b);
    repeat (at - 1) step();
    clear = 1'b1;
    #1 chk("clr_sready", sample_ready, 0);
    step();
    clear = 1'b0;
    hist.delete();
    chk("clr_busy", busy, 0);
    chk("clr_rv", result_valid, 0);
    repeat (WIDTH + 2) begin
      step();
      if (result_valid) rose = 1'b1;
    end
    chk("clr_never_valid", rose, 0);
    $display("clear at MAC edge %0d", at);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill, latency and sliding window: kernel all ones, six 1s then a 0.
    add_vec(0, 1, 6'h3F, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= WIDTH; i++) add_vec(0, 0, 0, 1, 1, 0, 1, 0, (i == WIDTH), 0);
    for (int i = 1; i < WIDTH; i++)  add_vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 6);
    add_vec(0, 0, 0, 0, 0, 1, 0, 0, 0, 6);
    add_vec(0, 0, 0, 1, 0, 0, 1, 0, 1, 6);
    for (int i = 1; i < WIDTH; i++)  add_vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 5);
    add_vec(0, 0, 0, 0, 0, 1, 0, 0, 0, 5);

    do_reset();
    foreach (vecs[i]) begin
      clear = vecs[i].clr; kernel_load = vecs[i].kl; kernel_in = vecs[i].kin;
      sample_valid = vecs[i].sv; sample_bit = vecs[i].sb; result_ready = vecs[i].rr;
      #1 chk($sformatf("vec%0d_sready", i), sample_ready, vecs[i].e_sr);
      step();
      chk($sformatf("vec%0d_rv", i), result_valid, vecs[i].e_rv);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_result", i), result, vecs[i].e_res);
      $display("vec %0d: rv=%0d busy=%0d result=%0d", i, result_valid, busy, result);
    end
    idle_inputs();

    // Kernel masking with 10 cycles of backpressure.
    do_reset();
    load_kernel(6'b101010);
    send(1); send(0); send(1); send(1); send(0); send(0);
    get_result("mask", 0, 10);
    chk("mask_hold", result, 2);

    // kernel_load on MAC edge 3 is ignored.
    send(1);
    step(); step();
    kernel_load = 1'b1; kernel_in = ~kernel_m;
    step();
    kernel_load = 1'b0;
    get_result("kl_in_mac", 3, 0);

    // clear on MAC edge 3, then a fresh fill of WIDTH samples.
    mac_clear(1, 3);
    send(1); send(1); send(0); send(1); send(0); send(1);
    get_result("after_clear", 0, 1);

    // clear together with kernel_load in IDLE: kernel must not change.
    clear = 1'b1; kernel_load = 1'b1; kernel_in = 6'b010101;
    #1 chk("clr_kl_sready", sample_ready, 0);
    step();
    idle_inputs();
    hist.delete();
    chk("clr_kl_busy", busy, 0);
    send(1); send(0); send(1); send(0); send(1); send(0);
    get_result("clr_kl", 0, 0);
    chk("clr_kl_value", result, 3);

    // Asynchronous reset in MAC, then in DONE.
    send(1);
    step();
    #2 reset = 1'b1;
    #1;
    chk("arst_mac_busy", busy, 0);
    chk("arst_mac_rv", result_valid, 0);
    chk("arst_mac_sready", sample_ready, 0);
    #1 reset = 1'b0;
    step();
    hist.delete(); kernel_m = '0;
    load_kernel(6'h3F);
    for (int i = 0; i < WIDTH; i++) send(1);
    repeat (WIDTH) step();
    chk("arst_done_pre_rv", result_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_done_rv", result_valid, 0);
    chk("arst_done_busy", busy, 0);
    chk("arst_done_result", result, 0);
    #1 reset = 1'b0;
    step();
    hist.delete(); kernel_m = '0;
    load_kernel(6'h3F);
    for (int i = 0; i < WIDTH; i++) send(1);
    get_result("arst_refill", 0, 0);

    // Randomized traffic.
    load_kernel(WIDTH'($urandom));
    for (int it = 0; it < 120; it++) begin
      int r = $urandom_range(0, 99);
      if (r < 10) begin
        load_kernel(WIDTH'($urandom));
      end else if (r < 15) begin
        clear = 1'b1; kernel_load = 1'($urandom); kernel_in = WIDTH'($urandom);
        sample_valid = 1'($urandom); sample_bit = 1'($urandom);
        #1 chk("rnd_clr_sready", sample_ready, 0);
        step();
        idle_inputs();
        hist.delete();
        chk("rnd_clr_busy", busy, 0);
      end else begin
        bit b = 1'($urandom);
        if (hist.size() >= WIDTH - 1 && $urandom_range(0, 7) == 0) begin
          mac_clear(b, $urandom_range(1, WIDTH));
        end else begin
          send(b);
          if (hist.size() == WIDTH) get_result("rnd", 0, $urandom_range(0, 3));
        end
      end
      repeat ($urandom_range(0, 2)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
